// File: rtl/cdb_arbiter_pkg.sv
// Helpers for the CDB arbiter: the multiplier issue-credit test.
package cdb_arbiter_pkg;

    // A new multiply may issue only if every outstanding result still has a FIFO slot.
    function automatic logic has_credit(input int unsigned fifo_count,
                                        input int unsigned inflight,
                                        input int unsigned depth);
        return (fifo_count + inflight) < depth;
    endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types. fu_output_t is the record a functional unit hands to the CDB.
package rv32i_types;

    typedef struct packed {
        logic        valid;
        logic [7:0]  rob_id;
        logic [5:0]  rd_phys;
        logic [4:0]  rd_arch;
        logic [31:0] result;
    } fu_output_t;

endpackage

// File: rtl/cdb_lane_fifo.sv
// One-lane circular buffer holding multiplier results that lost CDB arbitration.
module cdb_lane_fifo
    import rv32i_types::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fu_output_t    push_data,
    input  logic          pop,
    output fu_output_t    head,
    output logic [CW-1:0] count
);

    fu_output_t    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    always @(posedge clk) begin
        if (!rst) assert (!(push && count == CW'(DEPTH)));
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-lane merge of ALU and multiplier completions onto one registered CDB slot,
// with multiplier credits and a starvation guard that throttles ALU issue.
module cdb_arbiter
    import rv32i_types::*;
    import cdb_arbiter_pkg::*;
#(
    parameter int SS             = 2,
    parameter int MUL_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SS-1:0] alu_valid,
    input  fu_output_t    alu_result [SS],
    input  logic [SS-1:0] mul_issue,
    input  logic [SS-1:0] mul_valid,
    input  fu_output_t    mul_result [SS],
    output fu_output_t    cdb [SS],
    output logic [SS-1:0] write_from_fu,
    output logic [SS-1:0] alu_status,
    output logic [SS-1:0] mult_status
);

    localparam int CW  = $clog2(MUL_FIFO_DEPTH) + 1;
    localparam int AGW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [AGW-1:0] AGE_MAX = AGW'(STARVE_LIMIT - 1);

    for (genvar i = 0; i < SS; i++) begin : g_lane
        fu_output_t     head;
        fu_output_t     cdb_q;
        logic           wff_q;
        logic [CW-1:0]  count;
        logic [CW-1:0]  inflight;
        logic [AGW-1:0] age;
        logic           head_win;
        logic           byp_win;
        logic           push;

        // Priority: ALU, then buffered head, then bypass only into an empty FIFO.
        always_comb begin
            head_win = !alu_valid[i] && (count != '0);
            byp_win  = !alu_valid[i] && (count == '0) && mul_valid[i];
            push     = mul_valid[i] && !byp_win;
        end

        cdb_lane_fifo #(.DEPTH(MUL_FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push),
            .push_data (mul_result[i]),
            .pop       (head_win),
            .head      (head),
            .count     (count)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cdb_q    <= '0;
                wff_q    <= 1'b0;
                inflight <= '0;
                age      <= '0;
            end else begin
                wff_q <= alu_valid[i] || head_win || byp_win;
                if (alu_valid[i])  cdb_q <= alu_result[i];
                else if (head_win) cdb_q <= head;
                else if (byp_win)  cdb_q <= mul_result[i];

                case ({mul_issue[i], mul_valid[i]})
                    2'b10:   inflight <= inflight + CW'(1);
                    2'b01:   inflight <= inflight - CW'(1);
                    default: inflight <= inflight;
                endcase

                // The head loses exactly when the FIFO is non-empty and the ALU takes the slot.
                if ((count != '0) && alu_valid[i])
                    age <= (age >= AGE_MAX) ? age : age + AGW'(1);
                else
                    age <= '0;
            end
        end

        assign cdb[i]           = cdb_q;
        assign write_from_fu[i] = wff_q;
        assign alu_status[i]    = (age < AGE_MAX);
        assign mult_status[i]   = has_credit(32'(count), 32'(inflight), MUL_FIFO_DEPTH);
    end

endmodule
